// File: rtl/ws_pe_pkg.sv
// ws_pe_pkg: shared widths, INT32 limits and the saturating/wrapping adder for the PE
package ws_pe_pkg;
  localparam int ACT_W  = 8;
  localparam int ACC_W  = 32;
  localparam int PROD_W = 16;
  localparam logic [ACC_W-1:0] ACC_MAX = 32'h7FFF_FFFF;
  localparam logic [ACC_W-1:0] ACC_MIN = 32'h8000_0000;

  // signed add with a guard bit; clamps to the INT32 limits when sat is set, wraps otherwise
  function automatic logic [ACC_W-1:0] sat_add32(input logic [ACC_W-1:0] x, input logic [ACC_W-1:0] y, input logic sat);
    logic [ACC_W:0] s;
    s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
    return (sat && (s[ACC_W] != s[ACC_W-1])) ? (s[ACC_W] ? ACC_MIN : ACC_MAX) : s[ACC_W-1:0];
  endfunction
endpackage

// File: rtl/pe_mac8.sv
// pe_mac8: INT8 multiply/bypass select, optional product register and INT32 accumulate; ovf port only with PE_OVF_FLAG_EN
module pe_mac8
  import ws_pe_pkg::*;
#(
  parameter int PIPE = 1,
  parameter int SAT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ACT_W-1:0] a,
  input  logic [ACT_W-1:0] w,
  input  logic             bypass,
  input  logic             en,
  input  logic             clr,
  output logic [ACC_W-1:0] acc
`ifdef PE_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  opnd;
  logic [ACC_W-1:0]  add_val;
  logic              add_go;

  assign prod = $signed(a) * $signed(w);
  assign opnd = bypass ? {{(ACC_W-ACT_W){a[ACT_W-1]}}, a} : {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  if (PIPE != 0) begin : g_pipe
    logic [ACC_W-1:0] prod_r;
    logic             vld;
    // stage 1: capture the operand; clr drops whatever is in flight
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        prod_r <= '0;
        vld    <= 1'b0;
      end else begin
        vld <= en && !clr;
        if (en) prod_r <= opnd;
      end
    assign add_val = prod_r;
    assign add_go  = vld;
  end else begin : g_comb
    assign add_val = opnd;
    assign add_go  = en;
  end

  // accumulate with clr taking priority over any pending add
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (clr) acc <= '0;
    else if (add_go) acc <= sat_add32(acc, add_val, SAT != 0);

`ifdef PE_OVF_FLAG_EN
  logic [ACC_W:0] sum;
  assign sum = {acc[ACC_W-1], acc} + {add_val[ACC_W-1], add_val};
  // sticky flag: any add whose true sum leaves the INT32 range
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (clr) ovf <= 1'b0;
    else if (add_go && (sum[ACC_W] != sum[ACC_W-1])) ovf <= 1'b1;
`endif
endmodule

// File: rtl/ws_pe.sv
// ws_pe: weight-stationary INT8 PE holding one weight and forwarding activation/load strobe east; ovf port only with PE_OVF_FLAG_EN
module ws_pe
  import ws_pe_pkg::*;
#(
  parameter int PIPE = 1,
  parameter int SAT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ACT_W-1:0] a_in,
  input  logic [ACT_W-1:0] b_in,
  input  logic             bypass,
  input  logic             en,
  input  logic             clr,
  input  logic             load_weight,
  output logic [ACT_W-1:0] a_out,
  output logic             load_weight_out,
  output logic [ACC_W-1:0] acc
`ifdef PE_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);
  logic [ACT_W-1:0] weight;

  // weight register; a same-cycle compute still sees the old value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) weight <= '0;
    else if (load_weight) weight <= b_in;

  // east-bound forwarding: strobe every cycle, activation only when enabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_out           <= '0;
      load_weight_out <= 1'b0;
    end else begin
      load_weight_out <= load_weight;
      if (en) a_out <= a_in;
    end

  pe_mac8 #(.PIPE(PIPE), .SAT(SAT)) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a_in),
    .w      (weight),
    .bypass (bypass),
    .en     (en),
    .clr    (clr),
    .acc    (acc)
`ifdef PE_OVF_FLAG_EN
    ,
    .ovf    (ovf)
`endif
  );
endmodule

// File: tb/tb_ws_pe.sv
// tb_ws_pe: directed checks of three ws_pe configurations sharing one stimulus stream
`timescale 1ns/1ps
module tb_ws_pe;
  logic clk = 1'b0;
  logic rst_n, bypass, en, clr, lw;
  logic [7:0] a, b;
  logic [7:0] ao0, ao1, ao2;
  logic lwo0, lwo1, lwo2;
  logic [31:0] acc0, acc1, acc2;
`ifdef PE_OVF_FLAG_EN
  logic ov0, ov1, ov2;
`endif
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ws_pe #(.PIPE(0), .SAT(0)) d0 (.clk(clk), .rst_n(rst_n), .a_in(a), .b_in(b), .bypass(bypass), .en(en), .clr(clr),
    .load_weight(lw), .a_out(ao0), .load_weight_out(lwo0), .acc(acc0)
`ifdef PE_OVF_FLAG_EN
    , .ovf(ov0)
`endif
  );
  ws_pe #(.PIPE(1), .SAT(0)) d1 (.clk(clk), .rst_n(rst_n), .a_in(a), .b_in(b), .bypass(bypass), .en(en), .clr(clr),
    .load_weight(lw), .a_out(ao1), .load_weight_out(lwo1), .acc(acc1)
`ifdef PE_OVF_FLAG_EN
    , .ovf(ov1)
`endif
  );
  ws_pe #(.PIPE(0), .SAT(1)) d2 (.clk(clk), .rst_n(rst_n), .a_in(a), .b_in(b), .bypass(bypass), .en(en), .clr(clr),
    .load_weight(lw), .a_out(ao2), .load_weight_out(lwo2), .acc(acc2)
`ifdef PE_OVF_FLAG_EN
    , .ovf(ov2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; bypass = 1'b0; en = 1'b0; clr = 1'b0; lw = 1'b0; a = 8'd0; b = 8'd0;
    #2;
    chk("rst_acc0", acc0, 32'd0);
    chk("rst_acc1", acc1, 32'd0);
    chk("rst_ao0", {24'd0, ao0}, 32'd0);
    chk("rst_lwo0", {31'd0, lwo0}, 32'd0);
`ifdef PE_OVF_FLAG_EN
    chk("rst_ovf0", {31'd0, ov0}, 32'd0);
`endif
    @(negedge clk) rst_n = 1'b1;
    // load weight 3, then a = 2,-1,5,7
    lw = 1'b1; b = 8'd3; step();
    chk("lwo_pulse", {31'd0, lwo0}, 32'd1);
    lw = 1'b0; en = 1'b1; a = 8'd2; step();
    chk("mac_acc_6", acc0, 32'd6);
    chk("aout_2", {24'd0, ao0}, 32'd2);
    chk("lwo_drop", {31'd0, lwo0}, 32'd0);
    a = 8'hFF; step();
    chk("mac_acc_3", acc0, 32'd3);
    chk("aout_m1", {24'd0, ao0}, 32'hFF);
    a = 8'd5; step();
    chk("mac_acc_18", acc0, 32'd18);
    a = 8'd7; step();
    chk("mac_acc_39", acc0, 32'd39);
    en = 1'b0; clr = 1'b1; step();
    chk("clr_acc0", acc0, 32'd0);
    chk("clr_acc1", acc1, 32'd0);
    // PIPE=1 latency with weight -4, then clr killing an in-flight product
    clr = 1'b0; lw = 1'b1; b = 8'hFC; step();
    lw = 1'b0; en = 1'b1; a = 8'd10; step();
    chk("pipe_edge1", acc1, 32'd0);
    chk("nopipe_m40", acc0, 32'hFFFF_FFD8);
    en = 1'b0; step();
    chk("pipe_edge2", acc1, 32'hFFFF_FFD8);
    en = 1'b1; a = 8'd1; clr = 1'b1; step();
    chk("pipe_clr", acc1, 32'd0);
    en = 1'b0; clr = 1'b0; step();
    chk("pipe_noleak1", acc1, 32'd0);
    step();
    chk("pipe_noleak2", acc1, 32'd0);
    // bypass with weight 9, a=-7 twice
    lw = 1'b1; b = 8'd9; step();
    lw = 1'b0; bypass = 1'b1; en = 1'b1; a = 8'hF9; step();
    step();
    chk("bypass_m14", acc0, 32'hFFFF_FFF2);
    chk("bypass_pipe_m7", acc1, 32'hFFFF_FFF9);
    bypass = 1'b0; en = 1'b0; clr = 1'b1; step();
    // hold with en=0, then simultaneous load/compute
    clr = 1'b0; lw = 1'b1; b = 8'd1; step();
    lw = 1'b0; a = 8'd5; step();
    a = 8'hFD; step();
    chk("hold_acc", acc0, 32'd0);
    chk("hold_aout", {24'd0, ao0}, 32'hF9);
    lw = 1'b1; b = 8'd2; en = 1'b1; a = 8'd5; step();
    chk("old_weight", acc0, 32'd5);
    lw = 1'b0; step();
    chk("new_weight", acc0, 32'd15);
    // async reset mid-accumulation
    en = 1'b0; clr = 1'b1; step();
    clr = 1'b0; bypass = 1'b1; en = 1'b1; a = 8'd123; lw = 1'b1; b = 8'd0; step();
    chk("pre_rst_acc", acc0, 32'd123);
    chk("pre_rst_lwo", {31'd0, lwo0}, 32'd1);
    rst_n = 1'b0; #1;
    chk("async_acc", acc0, 32'd0);
    chk("async_aout", {24'd0, ao0}, 32'd0);
    chk("async_lwo", {31'd0, lwo0}, 32'd0);
    bypass = 1'b0; en = 1'b0; lw = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    en = 1'b1; a = 8'd5; step();
    chk("async_weight", acc0, 32'd0);
    // saturation / wrap with -128 * -128
    en = 1'b0; lw = 1'b1; b = 8'h80; step();
    lw = 1'b0; en = 1'b1; a = 8'h80; step();
    chk("extreme_prod", acc0, 32'd16384);
    for (int i = 0; i < 131070; i++) step();
    chk("sat_below", acc2, 32'd2147467264);
    step();
    chk("sat_clamp", acc2, 32'h7FFF_FFFF);
    chk("pipe_lag", acc1, 32'd2147467264);
    step();
    chk("sat_stay", acc2, 32'h7FFF_FFFF);
    chk("wrap", acc0, 32'h8000_4000);
    chk("pipe_wrap", acc1, 32'h8000_0000);
`ifdef PE_OVF_FLAG_EN
    chk("ovf_wrap", {31'd0, ov0}, 32'd1);
    chk("ovf_sat", {31'd0, ov2}, 32'd1);
    chk("ovf_pipe", {31'd0, ov1}, 32'd1);
`endif
    en = 1'b0; step();
    chk("sat_hold", acc2, 32'h7FFF_FFFF);
    chk("pipe_drain", acc1, 32'h8000_4000);
    clr = 1'b1; step();
    chk("final_clr", acc2, 32'd0);
`ifdef PE_OVF_FLAG_EN
    chk("ovf_clr", {31'd0, ov2}, 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
